ctrl_fsm_gen2: RTL and testbench
================================

# ctrl_fsm_gen2

Second-generation control state machine for the programmable processor datapath. It fetches and decodes instructions from the instruction register and drives the PC, instruction register, data memory, register file, and ALU controls. Compared with the six-instruction controller it adds the following:
- parametrised address widths
- a load-immediate instruction
- optional jump / branch-on-zero with a PC load path
- a resumable halt
- a saturating executed-instruction counter

It sits between the IR/PC front end and the RF/ALU/data-memory datapath.

## Interface
- DADDR_W, 8, data-memory address width
- RADDR_W, 4, register-file address width; constraint 2*RADDR_W <= DADDR_W
- PC_W, 7, program counter width; constraint PC_W <= DADDR_W+RADDR_W
- CNT_W, 16, instruction counter width
- Derived: INSTR_W = 4+DADDR_W+RADDR_W (16 at defaults); opcode = IRout[INSTR_W-1 -: 4]
- Ports:
  - Clk  in  1  clock, all state on rising edge
  - Reset  in  1  asynchronous, active-high; forces INIT
  - IRout  in  INSTR_W  current instruction
  - Ra_zero  in  1  RF read port A value == 0
  - Resume  in  1  leave HALT
  - IR_ld  out  1  IR load enable
  - PC_clr  out  1  PC clear
  - PC_up  out  1  PC increment
  - PC_ld  out  1  PC load from PC_target
  - PC_target  out  PC_W  jump target = IRout[PC_W-1:0]
  - D_addr  out  DADDR_W  data-memory address
  - D_wr  out  1  data-memory write
  - RF_s  out  2  RF write mux: 0=ALU, 1=data mem, 2=immediate
  - Imm  out  DADDR_W  immediate = IRout[RADDR_W +: DADDR_W]
  - RF_W_addr, RF_Ra_addr, RF_Rb_addr  out  RADDR_W each
  - RF_W_en  out  1  RF write enable
  - Alu_s0  out  3  ALU op: 0=add, 1=sub, 2=idle/pass
  - Halted  out  1  high in HALT
  - StateOut  out  4  current state encoding
  - InstrCount  out  CNT_W  decoded-instruction count

## Operation
- States (encoding): INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9, LOADI 10, JUMP 11, BRZ 12.
- Defaults in every state unless listed: all enables 0, RF_s=0, Alu_s0=2, addresses 0. PC_target and Imm are always driven from IRout.
- Field aliases: dst = IRout[RADDR_W-1:0]; ra = IRout[DADDR_W+RADDR_W-1 -: RADDR_W]; rb = IRout[2*RADDR_W-1 -: RADDR_W]; maddr = IRout[RADDR_W +: DADDR_W] for LOAD; maddr = IRout[DADDR_W-1:0] for STORE.
- INIT: PC_clr=1 -> FETCH.
- FETCH: IR_ld=1, PC_up=1 -> DECODE.
- DECODE: dispatch on opcode; InstrCount increments here.
  - 0 -> NOOP, 1 -> STORE, 2 -> LOAD_A, 3 -> ADD, 4 -> SUB, 5 -> HALT, 6 -> LOADI, 7 -> JUMP, 8 -> BRZ.
  - Opcodes 9-15 go to NOOP.
- NOOP -> FETCH.
- LOAD_A: D_addr=maddr, RF_s=1, RF_W_addr=dst -> LOAD_B.
- LOAD_B: same as LOAD_A plus RF_W_en=1 -> FETCH.
- STORE: RF_Ra_addr=ra, D_addr=maddr, D_wr=1 -> FETCH.
- ADD / SUB: RF_Ra_addr=ra, RF_Rb_addr=rb, RF_W_addr=dst, RF_W_en=1, RF_s=0, Alu_s0=0 (ADD) or 1 (SUB) -> FETCH.
- LOADI: RF_s=2, RF_W_addr=dst, RF_W_en=1 -> FETCH.
- JUMP: PC_ld=1 -> FETCH.
- BRZ: RF_Ra_addr=ra; PC_ld=Ra_zero -> FETCH.
- HALT: Halted=1. Resume=1 -> FETCH; otherwise stay in HALT.
- InstrCount: cleared by Reset and in INIT. +1 on each DECODE cycle. Saturates at 2^CNT_W-1 (no wrap).

## Timing
- Moore outputs, decoded combinationally from the state register and IRout. There is no output register.
- Reset asserted: state = INIT immediately (asynchronous), so PC_clr=1 and all other enables 0, Alu_s0=2, InstrCount=0. Mid-instruction reset aborts that instruction; no partial write is issued after reset asserts.
- Reset release: first rising edge moves INIT -> FETCH.
- Cycles per instruction, FETCH inclusive:
  - 3 for NOOP, STORE, ADD, SUB, LOADI, JUMP, BRZ
  - 4 for LOAD
  - HALT: 2 to enter, plus 1 after Resume is sampled high
- IRout must be stable from the DECODE cycle through the last execute cycle. PC_up in FETCH and PC_ld in JUMP/BRZ never coincide.
- Resume is ignored outside HALT. Ra_zero is sampled only in BRZ.

## Configuration
- CTRL_BRANCH_EN defined: JUMP and BRZ states exist and opcodes 7/8 decode to them.
- CTRL_BRANCH_EN undefined: opcodes 7/8 decode to NOOP, PC_ld is constant 0, and JUMP/BRZ logic is absent. Encodings 11/12 are then unreachable.

## Test plan
- Reset low -> high -> low, IRout=16'h0000: StateOut 0 with PC_clr=1 during reset, then 1, 2, 3, 1; InstrCount=1 after the first DECODE.
- IRout=16'h2A53 (LOAD): LOAD_B cycle shows D_addr=8'hA5, RF_s=1, RF_W_addr=3, RF_W_en=1; 4 cycles FETCH-to-FETCH.
- IRout=16'h3DEF, then 16'h4DEF: ADD with Ra=D, Rb=E, W=F, Alu_s0=0; then SUB with Alu_s0=1; RF_W_en=1 only in the execute cycle.
- IRout=16'h6C72 (LOADI): Imm=8'hC7, RF_s=2, RF_W_addr=2, RF_W_en=1.
- CTRL_BRANCH_EN, IRout=16'h8345:
  - Ra_zero=1: PC_ld=1, PC_target=7'h45.
  - Ra_zero=0: PC_ld=0.
- Without the macro, the same instruction goes through NOOP with PC_ld=0.
- IRout=16'h5000 (HALT): Halted stays 1 for 10 cycles with Resume=0. Resume=1 returns to FETCH next edge. With CNT_W=2 and 5 instructions, InstrCount saturates at 3. Reset asserted mid-HALT forces state 0 asynchronously.

Source files
------------

// File: rtl/ctrl_fsm_gen2_if.sv
// Bundle between the gen2 control FSM and the IR/PC/RF/ALU datapath.
// master = controller (drives controls, reads IRout/Ra_zero/Resume); slave = datapath.
interface ctrl_fsm_gen2_if #(
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4,
    parameter int PC_W    = 7,
    parameter int CNT_W   = 16
);
    localparam int INSTR_W = 4 + DADDR_W + RADDR_W;

    logic [INSTR_W-1:0] IRout;
    logic               Ra_zero;
    logic               Resume;
    logic               IR_ld;
    logic               PC_clr;
    logic               PC_up;
    logic               PC_ld;
    logic [PC_W-1:0]    PC_target;
    logic [DADDR_W-1:0] D_addr;
    logic               D_wr;
    logic [1:0]         RF_s;
    logic [DADDR_W-1:0] Imm;
    logic [RADDR_W-1:0] RF_W_addr;
    logic [RADDR_W-1:0] RF_Ra_addr;
    logic [RADDR_W-1:0] RF_Rb_addr;
    logic               RF_W_en;
    logic [2:0]         Alu_s0;
    logic               Halted;
    logic [3:0]         StateOut;
    logic [CNT_W-1:0]   InstrCount;

    modport master (
        input  IRout, Ra_zero, Resume,
        output IR_ld, PC_clr, PC_up, PC_ld, PC_target, D_addr, D_wr, RF_s, Imm,
               RF_W_addr, RF_Ra_addr, RF_Rb_addr, RF_W_en, Alu_s0, Halted,
               StateOut, InstrCount
    );

    modport slave (
        output IRout, Ra_zero, Resume,
        input  IR_ld, PC_clr, PC_up, PC_ld, PC_target, D_addr, D_wr, RF_s, Imm,
               RF_W_addr, RF_Ra_addr, RF_Rb_addr, RF_W_en, Alu_s0, Halted,
               StateOut, InstrCount
    );
endinterface

// File: rtl/ctrl_fsm_gen2.sv
// Gen2 multi-cycle controller: Moore outputs decoded from state + IRout, no handshake/backpressure.
// CTRL_BRANCH_EN adds JUMP/BRZ (opcodes 7/8); otherwise they decode as NOOP and PC_ld is tied low.
module ctrl_fsm_gen2 #(
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4,
    parameter int PC_W    = 7,
    parameter int CNT_W   = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    ctrl_fsm_gen2_if.master bus
);
    localparam int INSTR_W = 4 + DADDR_W + RADDR_W;

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;
    localparam logic [3:0] S_LOADI  = 4'd10;
`ifdef CTRL_BRANCH_EN
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_BRZ    = 4'd12;
`endif

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [CNT_W-1:0]   r_cnt;

    logic [3:0]         w_opcode;
    logic [RADDR_W-1:0] w_dst;
    logic [RADDR_W-1:0] w_ra;
    logic [RADDR_W-1:0] w_rb;
    logic [DADDR_W-1:0] w_maddr_ld;
    logic [DADDR_W-1:0] w_maddr_st;

    logic               w_ir_ld;
    logic               w_pc_clr;
    logic               w_pc_up;
    logic [DADDR_W-1:0] w_d_addr;
    logic               w_d_wr;
    logic [1:0]         w_rf_s;
    logic [RADDR_W-1:0] w_w_addr;
    logic [RADDR_W-1:0] w_ra_addr;
    logic [RADDR_W-1:0] w_rb_addr;
    logic               w_w_en;
    logic [2:0]         w_alu;

    assign w_opcode   = bus.IRout[INSTR_W-1 -: 4];
    assign w_dst      = bus.IRout[RADDR_W-1:0];
    assign w_ra       = bus.IRout[DADDR_W+RADDR_W-1 -: RADDR_W];
    assign w_rb       = bus.IRout[2*RADDR_W-1 -: RADDR_W];
    assign w_maddr_ld = bus.IRout[RADDR_W +: DADDR_W];
    assign w_maddr_st = bus.IRout[DADDR_W-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    4'd1:    w_next = S_STORE;
                    4'd2:    w_next = S_LOAD_A;
                    4'd3:    w_next = S_ADD;
                    4'd4:    w_next = S_SUB;
                    4'd5:    w_next = S_HALT;
                    4'd6:    w_next = S_LOADI;
`ifdef CTRL_BRANCH_EN
                    4'd7:    w_next = S_JUMP;
                    4'd8:    w_next = S_BRZ;
`endif
                    default: w_next = S_NOOP;
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_HALT:   w_next = bus.Resume ? S_FETCH : S_HALT;
            // every remaining execute state is single-cycle and returns to FETCH
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt <= '0;
        end else if (r_state == S_DECODE && r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_ir_ld   = 1'b0;
        w_pc_clr  = 1'b0;
        w_pc_up   = 1'b0;
        w_d_addr  = '0;
        w_d_wr    = 1'b0;
        w_rf_s    = 2'd0;
        w_w_addr  = '0;
        w_ra_addr = '0;
        w_rb_addr = '0;
        w_w_en    = 1'b0;
        w_alu     = 3'd2;
        case (r_state)
            S_INIT:  w_pc_clr = 1'b1;
            S_FETCH: begin
                w_ir_ld = 1'b1;
                w_pc_up = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                w_d_addr = w_maddr_ld;
                w_rf_s   = 2'd1;
                w_w_addr = w_dst;
                w_w_en   = (r_state == S_LOAD_B);
            end
            S_STORE: begin
                w_ra_addr = w_ra;
                w_d_addr  = w_maddr_st;
                w_d_wr    = 1'b1;
            end
            S_ADD, S_SUB: begin
                w_ra_addr = w_ra;
                w_rb_addr = w_rb;
                w_w_addr  = w_dst;
                w_w_en    = 1'b1;
                w_alu     = (r_state == S_ADD) ? 3'd0 : 3'd1;
            end
            S_LOADI: begin
                w_rf_s   = 2'd2;
                w_w_addr = w_dst;
                w_w_en   = 1'b1;
            end
`ifdef CTRL_BRANCH_EN
            S_BRZ:   w_ra_addr = w_ra;
`endif
            default: ;
        endcase
    end

`ifdef CTRL_BRANCH_EN
    assign bus.PC_ld = (r_state == S_JUMP) || (r_state == S_BRZ && bus.Ra_zero);
`else
    logic w_unused_ra_zero;
    assign w_unused_ra_zero = bus.Ra_zero;
    assign bus.PC_ld        = 1'b0;
`endif

    assign bus.IR_ld      = w_ir_ld;
    assign bus.PC_clr     = w_pc_clr;
    assign bus.PC_up      = w_pc_up;
    assign bus.PC_target  = bus.IRout[PC_W-1:0];
    assign bus.D_addr     = w_d_addr;
    assign bus.D_wr       = w_d_wr;
    assign bus.RF_s       = w_rf_s;
    assign bus.Imm        = w_maddr_ld;
    assign bus.RF_W_addr  = w_w_addr;
    assign bus.RF_Ra_addr = w_ra_addr;
    assign bus.RF_Rb_addr = w_rb_addr;
    assign bus.RF_W_en    = w_w_en;
    assign bus.Alu_s0     = w_alu;
    assign bus.Halted     = (r_state == S_HALT);
    assign bus.StateOut   = r_state;
    assign bus.InstrCount = r_cnt;
endmodule

// File: tb/tb_ctrl_fsm_gen2.sv
// Bench for ctrl_fsm_gen2: directed program from the test plan, then random instruction streams
// compared every cycle against a per-instruction cycle-list model (default counter and a 2-bit counter).
module tb_ctrl_fsm_gen2;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic        ra_zero = 1'b0;
    logic        resume = 1'b0;

    int checks = 0;
    int errors = 0;

    ctrl_fsm_gen2_if #(.DADDR_W(8), .RADDR_W(4), .PC_W(7), .CNT_W(16)) bus_a ();
    ctrl_fsm_gen2_if #(.DADDR_W(8), .RADDR_W(4), .PC_W(7), .CNT_W(2))  bus_s ();

    assign bus_a.IRout   = ir;
    assign bus_a.Ra_zero = ra_zero;
    assign bus_a.Resume  = resume;
    assign bus_s.IRout   = ir;
    assign bus_s.Ra_zero = ra_zero;
    assign bus_s.Resume  = resume;

    ctrl_fsm_gen2 #(.DADDR_W(8), .RADDR_W(4), .PC_W(7), .CNT_W(16)) dut (
        .Clk(clk), .Reset(rst), .bus(bus_a)
    );
    ctrl_fsm_gen2 #(.DADDR_W(8), .RADDR_W(4), .PC_W(7), .CNT_W(2)) dut_s (
        .Clk(clk), .Reset(rst), .bus(bus_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instruction is a list of state codes it walks through; HALT repeats until Resume.
    int m_state = 0;
    int m_seq[$];
    int m_cnt_a = 0;
    int m_cnt_s = 0;

    task automatic model_step();
        if (rst) begin
            m_state = 0;
            m_seq   = '{1, 2};
            m_cnt_a = 0;
            m_cnt_s = 0;
        end else begin
            if (m_state == 2) begin
                if (m_cnt_a < 65535) m_cnt_a++;
                if (m_cnt_s < 3) m_cnt_s++;
                case (ir[15:12])
                    4'd1:    m_seq = '{6, 1, 2};
                    4'd2:    m_seq = '{4, 5, 1, 2};
                    4'd3:    m_seq = '{7, 1, 2};
                    4'd4:    m_seq = '{8, 1, 2};
                    4'd5:    m_seq = '{9, 1, 2};
                    4'd6:    m_seq = '{10, 1, 2};
`ifdef CTRL_BRANCH_EN
                    4'd7:    m_seq = '{11, 1, 2};
                    4'd8:    m_seq = '{12, 1, 2};
`endif
                    default: m_seq = '{3, 1, 2};
                endcase
            end
            if (!(m_state == 9 && !resume)) m_state = m_seq.pop_front();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    typedef struct packed {
        logic       ir_ld, pc_clr, pc_up, pc_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic [1:0] rf_s;
        logic [3:0] w, ra, rb;
        logic       w_en;
        logic [2:0] alu;
        logic       halted;
    } exp_t;

    function automatic exp_t expect_for(input int st, input logic [15:0] i, input logic raz);
        exp_t e;
        e = '0;
        e.alu = 3'd2;
        case (st)
            0: e.pc_clr = 1'b1;
            1: begin e.ir_ld = 1'b1; e.pc_up = 1'b1; end
            4, 5: begin
                e.d_addr = i[11:4]; e.rf_s = 2'd1; e.w = i[3:0]; e.w_en = (st == 5);
            end
            6: begin e.ra = i[11:8]; e.d_addr = i[7:0]; e.d_wr = 1'b1; end
            7, 8: begin
                e.ra = i[11:8]; e.rb = i[7:4]; e.w = i[3:0]; e.w_en = 1'b1;
                e.alu = (st == 7) ? 3'd0 : 3'd1;
            end
            9:  e.halted = 1'b1;
            10: begin e.rf_s = 2'd2; e.w = i[3:0]; e.w_en = 1'b1; end
            11: e.pc_ld = 1'b1;
            12: begin e.ra = i[11:8]; e.pc_ld = raz; end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        e = expect_for(m_state, ir, ra_zero);
        chk("StateOut",   32'(bus_a.StateOut),   32'(m_state));
        chk("StateOut_s", 32'(bus_s.StateOut),   32'(m_state));
        chk("IR_ld",      32'(bus_a.IR_ld),      32'(e.ir_ld));
        chk("PC_clr",     32'(bus_a.PC_clr),     32'(e.pc_clr));
        chk("PC_up",      32'(bus_a.PC_up),      32'(e.pc_up));
        chk("PC_ld",      32'(bus_a.PC_ld),      32'(e.pc_ld));
        chk("PC_target",  32'(bus_a.PC_target),  32'(ir[6:0]));
        chk("D_addr",     32'(bus_a.D_addr),     32'(e.d_addr));
        chk("D_wr",       32'(bus_a.D_wr),       32'(e.d_wr));
        chk("RF_s",       32'(bus_a.RF_s),       32'(e.rf_s));
        chk("Imm",        32'(bus_a.Imm),        32'(ir[11:4]));
        chk("RF_W_addr",  32'(bus_a.RF_W_addr),  32'(e.w));
        chk("RF_Ra_addr", 32'(bus_a.RF_Ra_addr), 32'(e.ra));
        chk("RF_Rb_addr", 32'(bus_a.RF_Rb_addr), 32'(e.rb));
        chk("RF_W_en",    32'(bus_a.RF_W_en),    32'(e.w_en));
        chk("Alu_s0",     32'(bus_a.Alu_s0),     32'(e.alu));
        chk("Halted",     32'(bus_a.Halted),     32'(e.halted));
        chk("InstrCount", 32'(bus_a.InstrCount), 32'(m_cnt_a));
        chk("InstrCnt_s", 32'(bus_s.InstrCount), 32'(m_cnt_s));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset low -> high -> low with a NOOP in IR
        #2 rst = 1'b1;
        #1;
        chk("rst_state",  32'(bus_a.StateOut),   32'd0);
        chk("rst_pc_clr", 32'(bus_a.PC_clr),     32'd1);
        chk("rst_cnt",    32'(bus_a.InstrCount), 32'd0);
        chk("rst_alu",    32'(bus_a.Alu_s0),     32'd2);
        step(); step();
        rst = 1'b0;
        step(); chk("seq_fetch",  32'(bus_a.StateOut), 32'd1);
        step(); chk("seq_decode", 32'(bus_a.StateOut), 32'd2);
        step(); chk("seq_noop",   32'(bus_a.StateOut), 32'd3);
        chk("cnt_first", 32'(bus_a.InstrCount), 32'd1);
        step(); chk("seq_fetch2", 32'(bus_a.StateOut), 32'd1);

        // LOAD 2A53: FETCH, DECODE, LOAD_A, LOAD_B, back to FETCH
        ir = 16'h2A53;
        step(); step();
        chk("ld_a_state", 32'(bus_a.StateOut), 32'd4);
        chk("ld_a_wen",   32'(bus_a.RF_W_en),  32'd0);
        step();
        chk("ld_b_daddr", 32'(bus_a.D_addr),    32'hA5);
        chk("ld_b_rfs",   32'(bus_a.RF_s),      32'd1);
        chk("ld_b_waddr", 32'(bus_a.RF_W_addr), 32'd3);
        chk("ld_b_wen",   32'(bus_a.RF_W_en),   32'd1);
        step(); chk("ld_cpi4", 32'(bus_a.StateOut), 32'd1);

        // ADD 3DEF then SUB 4DEF
        ir = 16'h3DEF;
        step(); chk("add_dec_wen", 32'(bus_a.RF_W_en), 32'd0);
        step();
        chk("add_ra",  32'(bus_a.RF_Ra_addr), 32'hD);
        chk("add_rb",  32'(bus_a.RF_Rb_addr), 32'hE);
        chk("add_w",   32'(bus_a.RF_W_addr),  32'hF);
        chk("add_alu", 32'(bus_a.Alu_s0),     32'd0);
        chk("add_wen", 32'(bus_a.RF_W_en),    32'd1);
        step(); chk("add_fetch_wen", 32'(bus_a.RF_W_en), 32'd0);
        ir = 16'h4DEF;
        step(); step();
        chk("sub_state", 32'(bus_a.StateOut), 32'd8);
        chk("sub_alu",   32'(bus_a.Alu_s0),   32'd1);
        step();

        // LOADI 6C72
        ir = 16'h6C72;
        step(); step();
        chk("li_imm",   32'(bus_a.Imm),       32'hC7);
        chk("li_rfs",   32'(bus_a.RF_s),      32'd2);
        chk("li_waddr", 32'(bus_a.RF_W_addr), 32'd2);
        chk("li_wen",   32'(bus_a.RF_W_en),   32'd1);
        step();

        // BRZ 8345 taken, then not taken
        ir = 16'h8345;
        ra_zero = 1'b1;
        step(); step();
`ifdef CTRL_BRANCH_EN
        chk("brz_state",  32'(bus_a.StateOut),  32'd12);
        chk("brz_pcld",   32'(bus_a.PC_ld),     32'd1);
        chk("brz_target", 32'(bus_a.PC_target), 32'h45);
`else
        chk("brz_noop",   32'(bus_a.StateOut),  32'd3);
        chk("brz_pcld0",  32'(bus_a.PC_ld),     32'd0);
`endif
        step();
        ra_zero = 1'b0;
        step(); step();
        chk("brz_nt_pcld", 32'(bus_a.PC_ld), 32'd0);
        step();
        chk("cnt_seven", 32'(bus_a.InstrCount), 32'd7);
        chk("cnt_sat",   32'(bus_s.InstrCount), 32'd3);

        // HALT 5000: hold for 10 cycles, then Resume
        ir = 16'h5000;
        step(); step();
        for (int k = 0; k < 10; k++) begin
            chk("halt_hold", 32'(bus_a.Halted), 32'd1);
            step();
        end
        chk("halt_still", 32'(bus_a.StateOut), 32'd9);
        resume = 1'b1;
        step();
        chk("resume_fetch", 32'(bus_a.StateOut), 32'd1);
        resume = 1'b0;

        // HALT again, then asynchronous reset mid-HALT
        step(); step(); step();
        chk("halt2", 32'(bus_a.StateOut), 32'd9);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus_a.StateOut), 32'd0);
        chk("async_rst_halt",  32'(bus_a.Halted),   32'd0);
        chk("async_rst_cnt",   32'(bus_s.InstrCount), 32'd0);
        step();
        rst = 1'b0;

        // random instruction stream; IR only changes during FETCH
        for (int c = 0; c < 3000; c++) begin
            step();
            ra_zero = 1'($urandom_range(0, 1));
            resume  = ($urandom_range(0, 2) == 0);
            if (m_state == 1) ir = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
